uart_xcvr: RTL

Synthesizable, parametrised full-duplex UART transceiver, the RTL successor to the team's behavioural UART bench model. It converts a byte-wide valid/ready stream to and from an asynchronous serial line. Data width, parity, stop bits and baud rate are configurable. RX uses 16x oversampling, glitch rejection, error flags and overrun detection. It sits between board-level `RX`/`TX` pins and on-chip logic; the existing bench model remains the line-side partner in simulation.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 23 ++
 rtl/uart_xcvr.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state types and the oversampling divider helper.
package uart_pkg;

  localparam int PAR_NONE   = 0;
  localparam int PAR_ODD    = 1;
  localparam int PAR_EVEN   = 2;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  // Rounded clocks per oversample tick, never below 1.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider emitting a one-cycle tick16_o every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick16_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick16_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick16_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: valid/ready byte stream to/from an asynchronous serial line,
// TX timed on the shared tick16, RX 16x oversampled with its own start-aligned phase.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TX,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int   DW       = DATA_BITS;
  localparam int   DIV      = calc_div(CLK_HZ, BAUD);
  localparam logic ODD_BIT  = (PARITY == PAR_ODD);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_xcvr: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_xcvr: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_xcvr: PARITY must be 0..2");
  end

  logic tick16;
  uart_baud_gen #(.DIV(DIV)) u_baud (.clk(clk), .rst(rst), .tick16_o(tick16));

  // ---------------- transmitter ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [3:0]    tx_tick_q, tx_tick_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d;
  logic          tx_par_q, tx_par_d;
  logic          tx_line_q, tx_line_d;

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign TX       = tx_line_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    if (tx_state_q == TX_IDLE) begin
      if (tx_valid) begin
        tx_state_d = TX_START;
        tx_tick_d  = '0;
        tx_bit_d   = '0;
        tx_shift_d = tx_data;
        tx_par_d   = (^tx_data) ^ ODD_BIT;
        tx_line_d  = 1'b0;
      end
    end else if (tick16) begin
      tx_tick_d = tx_tick_q + 4'd1;
      if (tx_tick_q == LAST_TICK) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_line_d  = tx_shift_q[0];
          end
          TX_DATA: begin
            if (tx_bit_q == 3'(DW - 1)) begin
              tx_bit_d = '0;
              if (PARITY != PAR_NONE) begin
                tx_state_d = TX_PARITY;
                tx_line_d  = tx_par_q;
              end else begin
                tx_state_d = TX_STOP;
                tx_line_d  = 1'b1;
              end
            end else begin
              tx_bit_d   = tx_bit_q + 3'd1;
              tx_shift_d = tx_shift_q >> 1;
              tx_line_d  = tx_shift_q[1];
            end
          end
          TX_PARITY: begin
            tx_state_d = TX_STOP;
            tx_bit_d   = '0;
            tx_line_d  = 1'b1;
          end
          TX_STOP: begin
            if (tx_bit_q == 3'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
            else                                tx_bit_d   = tx_bit_q + 3'd1;
            tx_line_d = 1'b1;
          end
          default: tx_state_d = TX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ---------------- receiver ----------------
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [3:0]    rx_phase_q, rx_phase_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [DW-1:0] rx_shift_q, rx_shift_d;
  logic          rx_pchk_q, rx_pchk_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_perr_q, rx_perr_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          rx_done, rx_done_ferr;

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_phase_d   = rx_phase_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_pchk_d    = rx_pchk_q;
    rx_done      = 1'b0;
    rx_done_ferr = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_phase_d = '0;
        end
      end
      RX_START: begin
        if (tick16) begin
          rx_phase_d = rx_phase_q + 4'd1;
          if (rx_phase_q == MID_TICK) begin
            // A line already back high at mid-start is a glitch, not a frame.
            if (rx_sync_q) rx_state_d = RX_IDLE;
            else begin
              rx_state_d = RX_DATA;
              rx_phase_d = '0;
              rx_bit_d   = '0;
              rx_pchk_d  = 1'b0;
            end
          end
        end
      end
      RX_DATA: begin
        if (tick16) begin
          rx_phase_d = rx_phase_q + 4'd1;
          if (rx_phase_q == LAST_TICK) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[DW-1:1]};
            if (rx_bit_q == 3'(DW - 1))
              rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            else
              rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (tick16) begin
          rx_phase_d = rx_phase_q + 4'd1;
          if (rx_phase_q == LAST_TICK) begin
            rx_pchk_d  = (^rx_shift_q) ^ rx_sync_q ^ ODD_BIT;
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick16) begin
          rx_phase_d = rx_phase_q + 4'd1;
          if (rx_phase_q == LAST_TICK) begin
            rx_done      = 1'b1;
            rx_done_ferr = ~rx_sync_q;
            rx_state_d   = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
      default:      rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    rx_ovr_d   = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_shift_q;
        rx_perr_d  = rx_pchk_q;
        rx_ferr_d  = rx_done_ferr;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_phase_q <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pchk_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_phase_q <= rx_phase_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pchk_q  <= rx_pchk_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end
endmodule
